// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      RECV,
      STOP
   } uart_state_e;

   localparam int unsigned DEF_CLK_HZ   = 50_000_000;
   localparam int unsigned DEF_BIT_RATE = 9600;

   // Truncating divide: the bit period is rounded down to whole clocks.
   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_sync_filter.sv
// Two-flop synchroniser for the RX pin with an optional 2-of-3 majority sampler.
// Build option: UART_RX_MAJORITY_EN enables the majority voter.
module uart_sync_filter (
   input  logic clk,
   input  logic reset,
   input  logic rxd,
   output logic rxs,
   output logic sample
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         rxs  <= 1'b1;
      end else begin
         meta <= rxd;
         rxs  <= meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // hist[0] is rxs one cycle ago, hist[1] two cycles ago.
   logic [1:0] hist;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist <= 2'b11;
      end else begin
         hist <= {hist[0], rxs};
      end
   end

   assign sample = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
   assign sample = rxs;
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, LSB-first, one-cycle valid strobe per byte.
// Build option: UART_RX_MAJORITY_EN makes each bit sample a 2-of-3 vote.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
   parameter int unsigned BIT_RATE     = DEF_BIT_RATE,
   parameter int unsigned PAYLOAD_BITS = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic                    uart_rx_break,
   output logic                    uart_rx_valid,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

   localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT + 1);
   localparam int unsigned BIT_W          = $clog2(PAYLOAD_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);

   logic rxs;
   logic sample;

   uart_state_e             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic [PAYLOAD_BITS-1:0] data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    brk_q, brk_d;

   uart_sync_filter u_sync (
      .clk    (clk),
      .reset  (reset),
      .rxd    (uart_rxd),
      .rxs    (rxs),
      .sample (sample)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         brk_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         brk_q     <= brk_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      brk_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (uart_rx_en && !rxs) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         START: begin
            if (!uart_rx_en) begin
               state_d = IDLE;
            end else if (cnt_q == HALF_LAST) begin
               if (!sample) begin
                  state_d   = RECV;
                  cnt_d     = '0;
                  bit_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RECV: begin
            if (!uart_rx_en) begin
               state_d = IDLE;
            end else if (cnt_q == BIT_LAST) begin
               cnt_d                 = '0;
               shift_d               = shift_q >> 1;
               shift_d[PAYLOAD_BITS-1] = sample;
               bit_cnt_d             = bit_cnt_q + 1'b1;
               if (bit_cnt_q == DATA_LAST) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (!uart_rx_en) begin
               state_d = IDLE;
            end else if (cnt_q == BIT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (sample) begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end else if (shift_q == '0) begin
                  valid_d = 1'b1;
                  brk_d   = 1'b1;
                  data_d  = '0;
               end
               // Low stop bit with non-zero payload is a framing error: drop it.
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign uart_rx_valid = valid_q;
   assign uart_rx_break = brk_q;
   assign uart_rx_data  = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced bit period of 16 clocks.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       reset;
   logic       uart_rxd;
   logic       uart_rx_en;
   logic       uart_rx_break;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;

   int checks;
   int errors;
   int pulses;
   int aa_pulses;
   int wide;
   int stray;
   logic       prev_valid;
   logic [7:0] last_data;
   logic       last_brk;

   uart_rx #(
      .CLK_HZ       (50_000_000),
      .BIT_RATE     (3_125_000),
      .PAYLOAD_BITS (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .uart_rxd      (uart_rxd),
      .uart_rx_en    (uart_rx_en),
      .uart_rx_break (uart_rx_break),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_data  (uart_rx_data)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      pulses     = 0;
      aa_pulses  = 0;
      wide       = 0;
      stray      = 0;
      prev_valid = 1'b0;
      last_data  = 8'h00;
      last_brk   = 1'b0;
   end

   always @(negedge clk) begin
      if (uart_rx_valid === 1'b1) begin
         pulses++;
         last_data = uart_rx_data;
         last_brk  = uart_rx_break;
         if (uart_rx_data === 8'hAA) aa_pulses++;
         if (prev_valid === 1'b1) wide++;
      end
      if (uart_rx_valid !== 1'b1 && uart_rx_break !== 1'b0) stray++;
      prev_valid = uart_rx_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_bits(input int n);
      uart_rxd = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   // A low stop bit is released early so its tail is not taken as a start bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      if (stop_ok) begin
         uart_rxd = 1'b1;
         repeat (CPB) @(negedge clk);
      end else begin
         uart_rxd = 1'b0;
         repeat (CPB * 3 / 4) @(negedge clk);
         uart_rxd = 1'b1;
         repeat (CPB / 4) @(negedge clk);
      end
   endtask

   typedef struct {
      string      name;
      logic [7:0] payload;
      logic       stop;
      int         exp_pulses;
      logic [7:0] exp_data;
      logic       exp_brk;
   } vec_t;

   vec_t vecs[7];
   int   base;

   initial begin
      checks = 0;
      errors = 0;

      vecs[0] = '{"aa",      8'hAA, 1'b1, 1, 8'hAA, 1'b0};
      vecs[1] = '{"55",      8'h55, 1'b1, 1, 8'h55, 1'b0};
      vecs[2] = '{"zero",    8'h00, 1'b1, 1, 8'h00, 1'b0};
      vecs[3] = '{"ff",      8'hFF, 1'b1, 1, 8'hFF, 1'b0};
      vecs[4] = '{"framing", 8'h3C, 1'b0, 0, 8'hFF, 1'b0};
      vecs[5] = '{"brk_vec", 8'h00, 1'b0, 1, 8'h00, 1'b1};
      vecs[6] = '{"81",      8'h81, 1'b1, 1, 8'h81, 1'b0};

      reset      = 1'b1;
      uart_rxd   = 1'b1;
      uart_rx_en = 1'b1;
      #480;
      reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(uart_rx_valid), 32'd0);
      check("rst_break", 32'(uart_rx_break), 32'd0);
      check("rst_data",  32'(uart_rx_data),  32'd0);
      idle_bits(2);
      check("idle_pulses", 32'(pulses), 32'd0);

      for (int v = 0; v < 7; v++) begin
         base = pulses;
         send_frame(vecs[v].payload, vecs[v].stop);
         idle_bits(2);
         check({vecs[v].name, "_pulses"}, 32'(pulses - base), 32'(vecs[v].exp_pulses));
         check({vecs[v].name, "_data"},   32'(last_data),     32'(vecs[v].exp_data));
         check({vecs[v].name, "_brk"},    32'(last_brk),      32'(vecs[v].exp_brk));
      end

      // Glitch shorter than half a bit must be rejected.
      base = pulses;
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (4) @(negedge clk);
      idle_bits(2);
      check("glitch_pulses", 32'(pulses - base), 32'd0);
      send_frame(8'h55, 1'b1);
      idle_bits(2);
      check("post_glitch_pulses", 32'(pulses - base), 32'd1);
      check("post_glitch_data",   32'(last_data),     32'h55);

      base = aa_pulses;
      for (int f = 0; f < 8; f++) begin
         send_frame(8'hAA, 1'b1);
         repeat (50) @(negedge clk);
      end
      idle_bits(2);
      check("burst_aa_pulses", 32'(aa_pulses - base), 32'd8);
      check("burst_data", 32'(uart_rx_data), 32'hAA);

      // Reset mid-frame discards the partial byte and clears held data.
      base = pulses;
      uart_rxd = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      reset    = 1'b1;
      uart_rxd = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_valid", 32'(uart_rx_valid), 32'd0);
      check("midrst_data",  32'(uart_rx_data),  32'd0);
      reset = 1'b0;
      idle_bits(12);
      check("midrst_pulses", 32'(pulses - base), 32'd0);
      check("midrst_data_after", 32'(uart_rx_data), 32'd0);

      base = pulses;
      uart_rxd = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      check("break_pulses", 32'(pulses - base), 32'd1);
      check("break_flag",   32'(last_brk),      32'd1);
      check("break_data",   32'(last_data),     32'd0);
      uart_rxd   = 1'b1;
      uart_rx_en = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx_en = 1'b1;
      idle_bits(3);
      check("break_abort_pulses", 32'(pulses - base), 32'd1);

      base = pulses;
      uart_rx_en = 1'b0;
      send_frame(8'hFF, 1'b1);
      uart_rx_en = 1'b1;
      idle_bits(1);
      check("en_off_pulses", 32'(pulses - base), 32'd0);
      send_frame(8'h00, 1'b1);
      idle_bits(2);
      check("en_on_pulses", 32'(pulses - base), 32'd1);
      check("en_on_data",   32'(last_data),     32'd0);
      check("en_on_brk",    32'(last_brk),      32'd0);

      check("valid_width", 32'(wide),  32'd0);
      check("break_stray", 32'(stray), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
